shift_seq: RTL

Iterative shift/rotate sequencer for the execute stage. It captures a 16-bit operand, a shift count and a shift opcode, then drives one log-stage of the shifter per cycle: 8, then 4, then 2, then 1. Each stage's vacated bits are filled either with wrapped-around bits (rotate) or with zeros (shift). It replaces the single-cycle barrel shifter on multi-cycle execute paths and reports completion to the pipeline control through a start/busy/done handshake.

---
 rtl/shift_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Iterative 16-bit rotate/shift sequencer: one log-stage (8,4,2,1) per cycle, start/busy/done handshake.
// Optional build macro SHIFT_SEQ_SKIP_EN: stages whose count bit is 0 take no cycle.
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int SW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, stage_res;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [SW-1:0]    stg, first_stg, next_stg;
  logic             last_stg, zero_skip;

`ifdef SHIFT_SEQ_SKIP_EN
  logic [CNT_W-1:0] lower;

  // Index of the highest set bit (0 when v is empty).
  function automatic logic [SW-1:0] msb_idx(input logic [CNT_W-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < CNT_W; i++)
      if (v[i]) msb_idx = SW'(i);
  endfunction
`endif

  // One stage of the shifter; amount is 2^stg, fill is wrap (op[0]=0) or zero.
  always_comb begin
    int amt;
    amt       = 1 << stg;
    stage_res = work;
    if (cnt_q[stg]) begin
      if (!op_q[1])
        stage_res = (work << amt) | (op_q[0] ? '0 : (work >> (WIDTH - amt)));
      else
        stage_res = (work >> amt) | (op_q[0] ? '0 : (work << (WIDTH - amt)));
    end
  end

  always_comb begin
`ifdef SHIFT_SEQ_SKIP_EN
    first_stg = msb_idx(cnt);
    zero_skip = (cnt == '0);
    lower     = cnt_q & ((CNT_W'(1) << stg) - CNT_W'(1));
    last_stg  = (lower == '0);
    next_stg  = msb_idx(lower);
`else
    first_stg = SW'(CNT_W - 1);
    zero_skip = 1'b0;
    last_stg  = (stg == '0);
    next_stg  = stg - SW'(1);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = zero_skip ? DONE : SHIFT;
        else       state_nxt = IDLE;
      end
      SHIFT:   if (last_stg) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      stg   <= '0;
      out   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= start && (state == SHIFT);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work  <= in;
            cnt_q <= cnt;
            op_q  <= op;
            stg   <= first_stg;
            if (zero_skip) out <= in;
          end
        end
        SHIFT: begin
          work <= stage_res;
          stg  <= next_stg;
          if (last_stg) out <= stage_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
endmodule
